// File: rtl/gnn_pkg.sv
// Shared parameters, payload types and FSM encoding for the GNN replay engine.
package gnn_pkg;

    localparam int unsigned FV_W       = 16;
    localparam int unsigned NUM_VERTS  = 64;
    localparam int unsigned BANK_DEPTH = 1024;
    localparam int unsigned NB_DEPTH   = 1024;
    localparam int unsigned NUM_ITER   = 4;

    localparam int unsigned NUM_BANKS  = 4;
    localparam int unsigned FB_AW      = $clog2(BANK_DEPTH);
    localparam int unsigned NL_AW      = $clog2(NB_DEPTH);
    localparam int unsigned VID_W      = $clog2(NUM_VERTS);
    localparam int unsigned CA_W       = $clog2(NUM_VERTS / NUM_BANKS);
    localparam int unsigned ITER_W     = 2;
    localparam int unsigned NB_ID_W    = 16;
    localparam int unsigned NB_INFO_W  = 24;

    typedef logic [FV_W-1:0] fv_t;

    typedef struct packed {
        logic [7:0]  cnt;
        logic [15:0] start;
    } nb_info_t;

    typedef enum logic [2:0] {
        IDLE, INFO, SELF, NB_ID, NB_FV, WRITE, COPY, DONE
    } state_t;

    typedef enum logic [1:0] {
        ACC_HOLD, ACC_LOAD, ACC_ADD
    } acc_op_t;

    // Word address of a vertex inside its bank; ids beyond the bank range wrap.
    function automatic logic [FB_AW-1:0] fv_addr(input logic [NB_ID_W-1:0] vid);
        return FB_AW'(vid >> 2);
    endfunction

endpackage

// File: rtl/gnn_replay_top_sram_sp.sv
// Single-port synchronous-read RAM; the array is named mem for hierarchical access.
module sram_sp #(
    parameter int unsigned  DEPTH = 1024,
    parameter int unsigned  WIDTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/gnn_replay_top.sv
// Graph-aggregation replay engine: per iteration pong[v] = ping[v] + sum(ping[nbr]),
// then pong is copied back into ping; repeats NUM_ITER times after reset release.
module gnn_replay_top
    import gnn_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    output logic              task_complete,
    output logic [ITER_W-1:0] current_replay_iter
);

    state_t                     state;
    logic [VID_W-1:0]           v;
    logic [7:0]                 k;
    logic [7:0]                 nb_cnt;
    logic [15:0]                nb_start;
    logic [CA_W-1:0]            ca;
    logic                       copy_wr;
    logic [1:0]                 rd_bank;
    acc_op_t                    acc_op;
    fv_t                        acc;
    fv_t                        acc_c;
    fv_t                        ping_rd_c;

    logic [NUM_BANKS-1:0]       ping_we_c;
    logic [NUM_BANKS-1:0]       pong_we_c;
    logic [FB_AW-1:0]           ping_addr_c;
    logic [FB_AW-1:0]           pong_addr_c;
    logic [NUM_BANKS*FV_W-1:0]  ping_rdata;
    logic [NUM_BANKS*FV_W-1:0]  pong_rdata;
    logic [NB_INFO_W-1:0]       info_rdata;
    nb_info_t                   info_c;
    logic [NB_ID_W-1:0]         nb_id_c;
    logic [NL_AW-1:0]           list_addr_c;

    assign info_c      = nb_info_t'(info_rdata);
    assign list_addr_c = NL_AW'(nb_start + 16'(k));
    assign ping_rd_c   = ping_rdata[32'(rd_bank)*FV_W +: FV_W];

    // Feature banks: instance b holds vertices with v[1:0] == b.
    sram_sp #(.DEPTH(BANK_DEPTH), .WIDTH(FV_W)) u_fv_ping [NUM_BANKS-1:0] (
        .clk   (clk),
        .we    (ping_we_c),
        .addr  (ping_addr_c),
        .wdata (pong_rdata),
        .rdata (ping_rdata)
    );

    sram_sp #(.DEPTH(BANK_DEPTH), .WIDTH(FV_W)) u_fv_pong [NUM_BANKS-1:0] (
        .clk   (clk),
        .we    (pong_we_c),
        .addr  (pong_addr_c),
        .wdata (acc_c),
        .rdata (pong_rdata)
    );

    sram_sp #(.DEPTH(NUM_VERTS), .WIDTH(NB_INFO_W)) u_nb_info (
        .clk   (clk),
        .we    (1'b0),
        .addr  (v),
        .wdata ('0),
        .rdata (info_rdata)
    );

    sram_sp #(.DEPTH(NB_DEPTH), .WIDTH(NB_ID_W)) u_nb_list (
        .clk   (clk),
        .we    (1'b0),
        .addr  (list_addr_c),
        .wdata ('0),
        .rdata (nb_id_c)
    );

    // The accumulator consumes ping read data one cycle after the read was issued.
    always_comb begin
        acc_c = acc;
        case (acc_op)
            ACC_LOAD: acc_c = ping_rd_c;
            ACC_ADD:  acc_c = acc + ping_rd_c;
            default:  acc_c = acc;
        endcase
    end

    // Memory strobes decoded from the current state.
    always_comb begin
        ping_we_c   = '0;
        pong_we_c   = '0;
        ping_addr_c = '0;
        pong_addr_c = '0;
        case (state)
            SELF:  ping_addr_c = fv_addr(NB_ID_W'(v));
            NB_FV: ping_addr_c = fv_addr(nb_id_c);
            WRITE: begin
                pong_addr_c = fv_addr(NB_ID_W'(v));
                pong_we_c   = 4'b0001 << v[1:0];
            end
            COPY: begin
                pong_addr_c = FB_AW'(ca);
                ping_addr_c = FB_AW'(ca);
                ping_we_c   = {NUM_BANKS{copy_wr}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= IDLE;
            v                   <= '0;
            k                   <= '0;
            nb_cnt              <= '0;
            nb_start            <= '0;
            ca                  <= '0;
            copy_wr             <= 1'b0;
            rd_bank             <= '0;
            acc_op              <= ACC_HOLD;
            acc                 <= '0;
            task_complete       <= 1'b0;
            current_replay_iter <= '0;
        end else begin
            acc    <= acc_c;
            acc_op <= ACC_HOLD;
            case (state)
                IDLE: begin
                    v     <= '0;
                    state <= INFO;
                end
                INFO: state <= SELF;
                SELF: begin
                    nb_cnt   <= info_c.cnt;
                    nb_start <= info_c.start;
                    k        <= '0;
                    acc_op   <= ACC_LOAD;
                    rd_bank  <= v[1:0];
                    state    <= (info_c.cnt == 8'd0) ? WRITE : NB_ID;
                end
                NB_ID: state <= NB_FV;
                NB_FV: begin
                    acc_op  <= ACC_ADD;
                    rd_bank <= nb_id_c[1:0];
                    k       <= k + 8'd1;
                    state   <= (k + 8'd1 == nb_cnt) ? WRITE : NB_ID;
                end
                WRITE: begin
                    if (v == VID_W'(NUM_VERTS - 1)) begin
                        ca      <= '0;
                        copy_wr <= 1'b0;
                        state   <= COPY;
                    end else begin
                        v     <= v + 1'b1;
                        state <= INFO;
                    end
                end
                COPY: begin
                    copy_wr <= ~copy_wr;
                    if (copy_wr) begin
                        if (ca == CA_W'(NUM_VERTS / NUM_BANKS - 1)) begin
                            if (current_replay_iter == ITER_W'(NUM_ITER - 1)) begin
                                task_complete <= 1'b1;
                                state         <= DONE;
                            end else begin
                                current_replay_iter <= current_replay_iter + 1'b1;
                                v                   <= '0;
                                state               <= INFO;
                            end
                        end else begin
                            ca <= ca + 1'b1;
                        end
                    end
                end
                DONE: state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gnn_replay_top.sv
// Directed self-checking bench for gnn_replay_top using hierarchical memory preload.
module tb_gnn_replay_top;
    import gnn_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       task_complete;
    logic [1:0] current_replay_iter;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    gnn_replay_top dut (
        .clk                 (clk),
        .reset               (reset),
        .task_complete       (task_complete),
        .current_replay_iter (current_replay_iter)
    );

    task automatic set_fv(input bit pong, input int b, input int a, input fv_t val);
        logic [9:0] ad;
        logic [2:0] sel;
        ad  = 10'(a);
        sel = {pong, 2'(b)};
        case (sel)
            3'd0: dut.u_fv_ping[0].mem[ad] = val;
            3'd1: dut.u_fv_ping[1].mem[ad] = val;
            3'd2: dut.u_fv_ping[2].mem[ad] = val;
            3'd3: dut.u_fv_ping[3].mem[ad] = val;
            3'd4: dut.u_fv_pong[0].mem[ad] = val;
            3'd5: dut.u_fv_pong[1].mem[ad] = val;
            3'd6: dut.u_fv_pong[2].mem[ad] = val;
            default: dut.u_fv_pong[3].mem[ad] = val;
        endcase
    endtask

    function automatic fv_t get_pong(input int vtx);
        logic [9:0] ad;
        logic [1:0] b;
        ad = 10'(vtx / 4);
        b  = 2'(vtx % 4);
        case (b)
            2'd0: return dut.u_fv_pong[0].mem[ad];
            2'd1: return dut.u_fv_pong[1].mem[ad];
            2'd2: return dut.u_fv_pong[2].mem[ad];
            default: return dut.u_fv_pong[3].mem[ad];
        endcase
    endfunction

    task automatic set_ping(input int vtx, input fv_t val);
        set_fv(1'b0, vtx % 4, vtx / 4, val);
    endtask

    task automatic set_info(input int vtx, input int cnt, input int start);
        dut.u_nb_info.mem[6'(vtx)] = {8'(cnt), 16'(start)};
    endtask

    task automatic set_list(input int idx, input int id);
        dut.u_nb_list.mem[10'(idx)] = 16'(id);
    endtask

    // Holds the block in reset and zeroes every memory.
    task automatic clear_and_hold();
        @(negedge clk);
        reset = 1'b0;
        for (int b = 0; b < 4; b++) begin
            for (int a = 0; a < 1024; a++) begin
                set_fv(1'b0, b, a, 16'h0);
                set_fv(1'b1, b, a, 16'h0);
            end
        end
        for (int i = 0; i < 64; i++) set_info(i, 0, 0);
        for (int i = 0; i < 1024; i++) set_list(i, 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_iter(input logic [1:0] target);
        for (int i = 0; i < 2000; i++) begin
            if (current_replay_iter === target) break;
            @(negedge clk);
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 2000; i++) begin
            if (task_complete === 1'b1) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        clear_and_hold();
        #1;
        checks++;
        if (task_complete !== 1'b0) begin
            failures++;
            $display("FAIL reset_tc: got %0b expected 0", task_complete);
        end
        checks++;
        if (current_replay_iter !== 2'd0) begin
            failures++;
            $display("FAIL reset_iter: got %0d expected 0", current_replay_iter);
        end
        release_reset();
        repeat (5) @(negedge clk);
        checks++;
        if (task_complete !== 1'b0 || current_replay_iter !== 2'd0) begin
            failures++;
            $display("FAIL early_run: tc=%0b iter=%0d expected tc=0 iter=0",
                     task_complete, current_replay_iter);
        end
    endtask

    task automatic test_identity();
        fv_t got;
        clear_and_hold();
        for (int i = 0; i < 64; i++) set_ping(i, fv_t'(i));
        release_reset();
        for (int it = 1; it <= 4; it++) begin
            if (it < 4) begin
                wait_iter(2'(it));
                checks++;
                if (current_replay_iter !== 2'(it) || task_complete !== 1'b0) begin
                    failures++;
                    $display("FAIL ident_iter%0d: iter=%0d tc=%0b expected iter=%0d tc=0",
                             it, current_replay_iter, task_complete, it);
                end
            end else begin
                wait_done();
                checks++;
                if (task_complete !== 1'b1 || current_replay_iter !== 2'd3) begin
                    failures++;
                    $display("FAIL ident_done: tc=%0b iter=%0d expected tc=1 iter=3",
                             task_complete, current_replay_iter);
                end
            end
            for (int i = 0; i < 64; i++) begin
                got = get_pong(i);
                checks++;
                if (got !== fv_t'(i)) begin
                    failures++;
                    $display("FAIL ident_pong it%0d v%0d: got %h expected %h", it, i, got, fv_t'(i));
                end
            end
        end
        repeat (40) @(negedge clk);
        checks++;
        if (task_complete !== 1'b1 || current_replay_iter !== 2'd3) begin
            failures++;
            $display("FAIL done_sticky: tc=%0b iter=%0d expected tc=1 iter=3",
                     task_complete, current_replay_iter);
        end
    endtask

    task automatic test_neighbour();
        fv_t exp0 [4] = '{16'd3, 16'd5, 16'd7, 16'd9};
        fv_t got;
        clear_and_hold();
        set_info(0, 1, 0);
        set_list(0, 1);
        set_ping(0, 16'd1);
        set_ping(1, 16'd2);
        release_reset();
        for (int it = 0; it < 4; it++) begin
            if (it < 3) wait_iter(2'(it + 1));
            else wait_done();
            got = get_pong(0);
            checks++;
            if (got !== exp0[it]) begin
                failures++;
                $display("FAIL nbr_pong0 it%0d: got %0d expected %0d", it, got, exp0[it]);
            end
            got = get_pong(1);
            checks++;
            if (got !== 16'd2) begin
                failures++;
                $display("FAIL nbr_pong1 it%0d: got %0d expected 2", it, got);
            end
        end
    endtask

    task automatic test_self_loop();
        fv_t exp5 [4] = '{16'd2, 16'd4, 16'd8, 16'd16};
        fv_t got;
        clear_and_hold();
        set_info(5, 1, 10);
        set_list(10, 5);
        set_ping(5, 16'd1);
        release_reset();
        for (int it = 0; it < 4; it++) begin
            if (it < 3) wait_iter(2'(it + 1));
            else wait_done();
            got = get_pong(5);
            checks++;
            if (got !== exp5[it]) begin
                failures++;
                $display("FAIL self_pong5 it%0d: got %0d expected %0d", it, got, exp5[it]);
            end
        end
    endtask

    task automatic test_overflow();
        fv_t got;
        clear_and_hold();
        set_info(2, 1, 20);
        set_list(20, 3);
        set_ping(2, 16'hFFFF);
        set_ping(3, 16'h0002);
        release_reset();
        wait_iter(2'd1);
        got = get_pong(2);
        checks++;
        if (got !== 16'h0001) begin
            failures++;
            $display("FAIL overflow_pong2: got %h expected 0001", got);
        end
        got = get_pong(3);
        checks++;
        if (got !== 16'h0002) begin
            failures++;
            $display("FAIL overflow_pong3: got %h expected 0002", got);
        end
    endtask

    // Also covers list-index wrap (1023 -> 0) and an out-of-range neighbour id.
    task automatic test_bank_mapping();
        fv_t got;
        clear_and_hold();
        set_info(6, 1, 30);
        set_list(30, 7);
        set_ping(6, 16'h0010);
        set_ping(7, 16'h0020);
        set_info(9, 2, 1023);
        set_list(1023, 8);
        set_list(0, 100);
        set_ping(8, 16'h0040);
        set_ping(9, 16'h0001);
        set_fv(1'b0, 0, 25, 16'h0005);
        release_reset();
        wait_iter(2'd1);
        got = dut.u_fv_pong[2].mem[1];
        checks++;
        if (got !== 16'h0030) begin
            failures++;
            $display("FAIL bank_v6: got %h expected 0030", got);
        end
        got = dut.u_fv_pong[3].mem[1];
        checks++;
        if (got !== 16'h0020) begin
            failures++;
            $display("FAIL bank_v7: got %h expected 0020", got);
        end
        got = dut.u_fv_pong[1].mem[2];
        checks++;
        if (got !== 16'h0046) begin
            failures++;
            $display("FAIL wrap_v9: got %h expected 0046", got);
        end
    endtask

    task automatic test_reset_mid();
        fv_t got;
        clear_and_hold();
        set_info(0, 1, 0);
        set_list(0, 1);
        set_ping(0, 16'd1);
        set_ping(1, 16'd2);
        release_reset();
        wait_iter(2'd1);
        repeat (60) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (task_complete !== 1'b0 || current_replay_iter !== 2'd0) begin
            failures++;
            $display("FAIL mid_reset: tc=%0b iter=%0d expected tc=0 iter=0",
                     task_complete, current_replay_iter);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        wait_iter(2'd1);
        got = get_pong(0);
        checks++;
        if (got !== 16'd5) begin
            failures++;
            $display("FAIL restart_it0: got %0d expected 5", got);
        end
        wait_done();
        got = get_pong(0);
        checks++;
        if (task_complete !== 1'b1 || current_replay_iter !== 2'd3 || got !== 16'd11) begin
            failures++;
            $display("FAIL restart_done: tc=%0b iter=%0d pong0=%0d expected tc=1 iter=3 pong0=11",
                     task_complete, current_replay_iter, got);
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_neighbour();
        test_self_loop();
        test_overflow();
        test_bank_mapping();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
